mdio_master: RTL and testbench

Clause-22 MDIO management-frame initiator. It issues read and write frames on MDC/MDIO toward the chip's MDIO register responder in the control subsystem. It is used as the on-board or bench-side configuration master and as the loopback driver for register-access self test. A simple command/response handshake on the host side is converted into serial frames with a programmable MDC rate and preamble length.

---
 rtl/mdio_master.sv | 148 ++++++++++++++
 tb/tb_mdio_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO frame initiator: turns a host command/response handshake into
// MDC/MDIO read and write frames with programmable MDC rate and preamble length.
module mdio_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        mdio_in
);

  localparam int DW = 9;
  localparam logic [DW-1:0] LAST = DW'(2*CLK_DIV-1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;

  state_t          state, state_n;
  logic [4:0]      bit_cnt, bit_cnt_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic            last_tick, accept, bit_step, done;
  logic [31:0]     frame_w, cur_sr, tx_sr;
  logic            wr_q, ta_err, mdio_s1, mdio_s;
  logic [15:0]     rd_sr;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign last_tick = (state != S_IDLE) && (div_cnt == LAST);
  assign accept    = cmd_valid && cmd_ready;
  assign bit_step  = accept || last_tick;
  assign div_n     = (state == S_IDLE || last_tick) ? '0 : div_cnt + 1'b1;

  // Everything after the preamble; read frames keep the line idle-high while released.
  assign frame_w = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                    cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};
  assign cur_sr  = (state == S_IDLE) ? frame_w : tx_sr;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    done      = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        state_n   = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
        bit_cnt_n = '0;
      end
      S_PRE: if (last_tick) begin
        if (bit_cnt == 5'(PREAMBLE_LEN-1)) begin
          state_n   = S_HDR;
          bit_cnt_n = '0;
        end else bit_cnt_n = bit_cnt + 1'b1;
      end
      S_HDR: if (last_tick) begin
        if (bit_cnt == 5'd13) begin
          state_n   = S_TA;
          bit_cnt_n = '0;
        end else bit_cnt_n = bit_cnt + 1'b1;
      end
      S_TA: if (last_tick) begin
        if (bit_cnt == 5'd1) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end else bit_cnt_n = bit_cnt + 1'b1;
      end
      S_DATA: if (last_tick) begin
        if (bit_cnt == 5'd15) begin
          state_n   = S_IDLE;
          bit_cnt_n = '0;
          done      = 1'b1;
        end else bit_cnt_n = bit_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdio_s1   <= 1'b1;
      mdio_s    <= 1'b1;
      mdc       <= 1'b0;
      mdio_out  <= 1'b1;
      mdio_oen  <= 1'b1;
      tx_sr     <= '0;
      wr_q      <= 1'b0;
      ta_err    <= 1'b0;
      rd_sr     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mdio_s1   <= mdio_in;
      mdio_s    <= mdio_s1;
      rsp_valid <= 1'b0;
      // Registered from next-state values so mdc is glitch-free yet in phase with div_cnt.
      mdc       <= (state_n != S_IDLE) && (div_n >= HALF);
      if (accept) wr_q <= cmd_write;
      if (bit_step) begin
        if (state_n == S_IDLE) begin
          mdio_out <= 1'b1;
          mdio_oen <= 1'b1;
        end else if (state_n == S_PRE) begin
          mdio_out <= 1'b1;
          mdio_oen <= 1'b0;
          tx_sr    <= cur_sr;
        end else begin
          mdio_out <= cur_sr[31];
          mdio_oen <= !wr_q && (state_n == S_TA || state_n == S_DATA);
          tx_sr    <= {cur_sr[30:0], 1'b0};
        end
      end
      if (state == S_TA && last_tick && bit_cnt == 5'd1) ta_err <= mdio_s;
      if (state == S_DATA && last_tick) rd_sr <= {rd_sr[14:0], mdio_s};
      if (done) begin
        rsp_valid <= 1'b1;
        if (!wr_q) begin
          rsp_rdata <= {rd_sr[14:0], mdio_s};
          rsp_err   <= ta_err;
        end else rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: one DUT with a full preamble, one with it suppressed.
module tb_mdio_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid_a = 1'b0, cmd_valid_z = 1'b0;
  logic cmd_write = 1'b0;
  logic [4:0] cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic mdio_in = 1'b1;
  logic sel = 1'b0;

  logic a_ready, a_rv, a_err, a_busy, a_mdc, a_out, a_oen;
  logic z_ready, z_rv, z_err, z_busy, z_mdc, z_out, z_oen;
  logic [15:0] a_rd, z_rd;

  logic o_ready, o_rv, o_err, o_busy, o_mdc, o_out, o_oen;
  logic [15:0] o_rd;
  assign o_ready = sel ? z_ready : a_ready;
  assign o_rv    = sel ? z_rv    : a_rv;
  assign o_err   = sel ? z_err   : a_err;
  assign o_busy  = sel ? z_busy  : a_busy;
  assign o_mdc   = sel ? z_mdc   : a_mdc;
  assign o_out   = sel ? z_out   : a_out;
  assign o_oen   = sel ? z_oen   : a_oen;
  assign o_rd    = sel ? z_rd    : a_rd;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(a_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_err(a_err),
    .busy(a_busy), .mdc(a_mdc), .mdio_out(a_out), .mdio_oen(a_oen), .mdio_in(mdio_in));

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_dut_np (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_z), .cmd_ready(z_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(z_rv), .rsp_rdata(z_rd), .rsp_err(z_err),
    .busy(z_busy), .mdc(z_mdc), .mdio_out(z_out), .mdio_oen(z_oen), .mdio_in(mdio_in));

  // Issues one command and records the frame; the responder drives bit k+1 just after
  // the mdc rising edge of bit k, as a real PHY would.
  task automatic do_frame(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, input int plen, input bit resp_on,
                          input logic [15:0] rdat,
                          output logic [63:0] ob, output logic [63:0] eb,
                          output int mdc_bad, output int hold_bad, output int busy_bad,
                          output int lat, output logic [15:0] rd, output logic er);
    int nc, k, d, nb;
    logic cur_o, cur_e;
    nc = (plen + 32) * 4;
    ob = '0; eb = '0; mdc_bad = 0; hold_bad = 0; busy_bad = 0; lat = 0;
    rd = 'x; er = 1'bx; cur_o = 1'b0; cur_e = 1'b0;
    @(negedge clk);
    cmd_write = wr; cmd_phy_addr = phy; cmd_reg_addr = rg; cmd_wdata = wd;
    if (sel) cmd_valid_z = 1'b1; else cmd_valid_a = 1'b1;
    for (int j = 1; j <= nc + 8; j++) begin
      @(negedge clk);
      if (j == 1) begin cmd_valid_a = 1'b0; cmd_valid_z = 1'b0; end
      if (o_rv) begin lat = j; rd = o_rd; er = o_err; break; end
      if (j <= nc) begin
        k = (j - 1) / 4; d = (j - 1) % 4;
        if (d == 0) begin
          cur_o = o_out; cur_e = o_oen;
          ob = {ob[62:0], o_out}; eb = {eb[62:0], o_oen};
        end else if (o_out !== cur_o || o_oen !== cur_e) hold_bad++;
        if (o_mdc !== (d >= 2)) mdc_bad++;
        if (o_busy !== 1'b1) busy_bad++;
        if (resp_on && d == 2) begin
          nb = k + 1;
          if (nb == plen + 15) mdio_in = 1'b0;
          else if (nb >= plen + 16 && nb <= plen + 31) mdio_in = rdat[plen + 31 - nb];
          else mdio_in = 1'b1;
        end
      end
    end
    mdio_in = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({a_ready, a_busy, a_rv, a_err} !== 4'b1000) begin
      bad++; $display("FAIL reset_hs: got %b want 1000", {a_ready, a_busy, a_rv, a_err});
    end
    total++;
    if (a_rd !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", a_rd); end
    total++;
    if ({a_mdc, a_out, a_oen} !== 3'b011) begin
      bad++; $display("FAIL reset_bus: got %b want 011", {a_mdc, a_out, a_oen});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({a_ready, a_busy, a_mdc, a_out, a_oen} !== 5'b10011) begin
      bad++; $display("FAIL idle_after_reset: got %b want 10011", {a_ready, a_busy, a_mdc, a_out, a_oen});
    end
  endtask

  task automatic test_write;
    logic [63:0] ob, eb, exp; logic [15:0] rd; logic er;
    int mb, hb, bb, lat;
    exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00101, 2'b10, 16'hA5C3};
    do_frame(1'b1, 5'd1, 5'h05, 16'hA5C3, 32, 1'b0, 16'h0, ob, eb, mb, hb, bb, lat, rd, er);
    total++;
    if (ob !== exp) begin bad++; $display("FAIL wr_bits: got %h want %h", ob, exp); end
    total++;
    if (eb !== 64'h0) begin bad++; $display("FAIL wr_oen: got %h want 0", eb); end
    total++;
    if (mb != 0 || hb != 0 || bb != 0) begin
      bad++; $display("FAIL wr_timing: mdc_bad=%0d hold_bad=%0d busy_bad=%0d want 0", mb, hb, bb);
    end
    total++;
    if (lat != 257) begin bad++; $display("FAIL wr_latency: got %0d want 257", lat); end
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", er); end
    total++;
    if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
      bad++; $display("FAIL wr_end_idle: busy=%b ready=%b want 0 1", a_busy, a_ready);
    end
  endtask

  task automatic test_read;
    logic [63:0] ob, eb; logic [15:0] rd; logic er;
    logic [45:0] exph;
    int mb, hb, bb, lat;
    exph = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00011, 5'b00010};
    do_frame(1'b0, 5'd3, 5'h02, 16'h0, 32, 1'b1, 16'h1234, ob, eb, mb, hb, bb, lat, rd, er);
    total++;
    if (ob[63:18] !== exph) begin bad++; $display("FAIL rd_hdr: got %h want %h", ob[63:18], exph); end
    total++;
    if (eb !== 64'h0000_0000_0003_FFFF) begin
      bad++; $display("FAIL rd_oen: got %h want 000000000003ffff", eb);
    end
    total++;
    if (rd !== 16'h1234 || er !== 1'b0) begin
      bad++; $display("FAIL rd_data: got %h err=%b want 1234 err=0", rd, er);
    end
    total++;
    if (lat != 257 || mb != 0 || hb != 0) begin
      bad++; $display("FAIL rd_timing: lat=%0d mdc_bad=%0d hold_bad=%0d want 257 0 0", lat, mb, hb);
    end
  endtask

  task automatic test_read_noresp;
    logic [63:0] ob, eb; logic [15:0] rd; logic er;
    int mb, hb, bb, lat;
    do_frame(1'b0, 5'd7, 5'h11, 16'h0, 32, 1'b0, 16'h0, ob, eb, mb, hb, bb, lat, rd, er);
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL noresp_err: got %b want 1", er); end
    total++;
    if (rd !== 16'hFFFF) begin bad++; $display("FAIL noresp_data: got %h want ffff", rd); end
    // rsp_rdata holds after the pulse
    repeat (5) @(negedge clk);
    total++;
    if (a_rd !== 16'hFFFF || a_rv !== 1'b0) begin
      bad++; $display("FAIL rdata_hold: got %h rv=%b want ffff rv=0", a_rd, a_rv);
    end
  endtask

  task automatic test_back_to_back;
    int j1, j2, nrsp, rdy_bad;
    j1 = 0; j2 = 0; nrsp = 0; rdy_bad = 0;
    @(negedge clk);
    cmd_write = 1'b1; cmd_phy_addr = 5'd2; cmd_reg_addr = 5'd4; cmd_wdata = 16'h0F0F;
    cmd_valid_a = 1'b1;
    for (int j = 1; j <= 600; j++) begin
      @(negedge clk);
      if (a_rv) begin
        nrsp++;
        if (nrsp == 1) begin
          j1 = j;
          total++;
          if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", a_ready); end
          cmd_write = 1'b0;
        end else begin
          j2 = j;
          break;
        end
      end else if (a_ready !== 1'b0) rdy_bad++;
      if (j1 != 0 && j == j1 + 1) begin
        cmd_valid_a = 1'b0;
        total++;
        if ({a_busy, a_out, a_oen, a_mdc} !== 4'b1100) begin
          bad++; $display("FAIL b2b_start: got %b want 1100", {a_busy, a_out, a_oen, a_mdc});
        end
      end
      if (j1 != 0 && j == j1 + 3) begin
        total++;
        if (a_mdc !== 1'b1) begin bad++; $display("FAIL b2b_mdc: got %b want 1", a_mdc); end
      end
    end
    cmd_valid_a = 1'b0;
    total++;
    if (j1 != 257 || j2 != 514) begin
      bad++; $display("FAIL b2b_latency: got %0d %0d want 257 514", j1, j2);
    end
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL b2b_ready_busy: got %0d want 0", rdy_bad); end
    total++;
    if (a_err !== 1'b1 || a_rd !== 16'hFFFF) begin
      bad++; $display("FAIL b2b_read: got %h err=%b want ffff err=1", a_rd, a_err);
    end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] ob, eb, exp; logic [15:0] rd; logic er;
    int mb, hb, bb, lat, nrv;
    @(negedge clk);
    cmd_write = 1'b1; cmd_phy_addr = 5'd1; cmd_reg_addr = 5'h05; cmd_wdata = 16'hA5C3;
    cmd_valid_a = 1'b1;
    for (int j = 1; j <= 163; j++) begin
      @(negedge clk);
      if (j == 1) cmd_valid_a = 1'b0;
    end
    total++;
    if ({a_busy, a_oen, a_mdc} !== 3'b101) begin
      bad++; $display("FAIL pre_rst: got %b want 101", {a_busy, a_oen, a_mdc});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({a_busy, a_oen, a_mdc, a_out, a_ready} !== 5'b01011) begin
      bad++; $display("FAIL mid_rst: got %b want 01011", {a_busy, a_oen, a_mdc, a_out, a_ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nrv = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (a_rv) nrv++;
    end
    total++;
    if (nrv != 0 || a_ready !== 1'b1 || a_rd !== 16'h0) begin
      bad++; $display("FAIL post_rst: rsp=%0d ready=%b rdata=%h want 0 1 0000", nrv, a_ready, a_rd);
    end
    exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00101, 2'b10, 16'hA5C3};
    do_frame(1'b1, 5'd1, 5'h05, 16'hA5C3, 32, 1'b0, 16'h0, ob, eb, mb, hb, bb, lat, rd, er);
    total++;
    if (ob !== exp || lat != 257 || er !== 1'b0) begin
      bad++; $display("FAIL rst_rewrite: got %h lat=%0d err=%b want %h 257 0", ob, lat, er, exp);
    end
  endtask

  task automatic test_no_preamble;
    logic [63:0] ob, eb; logic [15:0] rd; logic er;
    int mb, hb, bb, lat;
    sel = 1'b1;
    do_frame(1'b0, 5'd0, 5'h1F, 16'h0, 0, 1'b1, 16'hBEEF, ob, eb, mb, hb, bb, lat, rd, er);
    total++;
    if (ob[31:28] !== 4'b0110) begin bad++; $display("FAIL np_start: got %b want 0110", ob[31:28]); end
    total++;
    if (ob[31:18] !== 14'b01_10_00000_11111) begin
      bad++; $display("FAIL np_hdr: got %b want 01100000011111", ob[31:18]);
    end
    total++;
    if (eb[31:0] !== 32'h0003_FFFF) begin bad++; $display("FAIL np_oen: got %h want 0003ffff", eb[31:0]); end
    total++;
    if (lat != 129) begin bad++; $display("FAIL np_latency: got %0d want 129", lat); end
    total++;
    if (rd !== 16'hBEEF || er !== 1'b0 || mb != 0 || hb != 0) begin
      bad++; $display("FAIL np_data: got %h err=%b mdc_bad=%0d hold_bad=%0d want beef 0 0 0", rd, er, mb, hb);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_noresp();
    test_back_to_back();
    test_reset_midframe();
    test_no_preamble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
